// File: rtl/mmio_io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_io_responder_if
//  Description : Bus bundle for the memory-mapped IO responder.
//                - CPU side: io_addr / io_dout / io_we in, io_din out
//                  (combinational load data).
//                - Input port: in_data / in_valid in, in_ready out.
//                - Output FIFO stream: out_data / out_valid out, out_ready in.
//                Modport "slave" is the responder's view; "master" is the
//                view of whatever drives the CPU and peripheral sides.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmio_io_responder_if;
    logic [31:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic [31:0] io_din;

    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output io_addr, io_dout, io_we, in_data, in_valid, out_ready,
        input  io_din, in_ready, out_data, out_valid
    );

    modport slave (
        input  io_addr, io_dout, io_we, in_data, in_valid, out_ready,
        output io_din, in_ready, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mmio_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_io_responder
//  Description : Responder end of the CPU memory-mapped IO bus. Decodes a
//                256-byte window at BASE_ADDR and bridges it to an LED
//                register, a valid/ready input capture port, an output FIFO
//                draining to a valid/ready consumer and a free-running
//                cycle counter.
//  Ports       : clk  - system clock, all state on posedge
//                rst  - synchronous active-low reset
//                bus  - mmio_io_responder_if.slave (CPU bus, input port,
//                       output FIFO stream)
//                led  - LED register, LED_W bits
//                irq  - registered interrupt (only with MMIO_IRQ_EN)
//  Register map (offset = io_addr[7:0], io_addr[1:0] ignored):
//                0x00 LED  0x04 IN_STAT  0x08 IN_DATA  0x0C FIFO_STAT
//                0x10 FIFO_PUSH  0x14 CYCLE  0x18 IRQ_EN (MMIO_IRQ_EN only)
//  Options     : `define MMIO_IRQ_EN adds the irq port and IRQ_EN register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_io_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LED_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    mmio_io_responder_if.slave    bus,
    output logic [LED_W-1:0]      led
`ifdef MMIO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_pw = c_aw + 1;

    // Word offsets (io_addr[7:2])
    localparam logic [5:0] c_off_led       = 6'h00;
    localparam logic [5:0] c_off_in_stat   = 6'h01;
    localparam logic [5:0] c_off_in_data   = 6'h02;
    localparam logic [5:0] c_off_fifo_stat = 6'h03;
    localparam logic [5:0] c_off_fifo_push = 6'h04;
    localparam logic [5:0] c_off_cycle     = 6'h05;
`ifdef MMIO_IRQ_EN
    localparam logic [5:0] c_off_irq_en    = 6'h06;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LED_W-1:0] r_led;
    logic             r_flag;
    logic [15:0]      r_in_data;
    logic             r_ovf;
    logic [31:0]      r_cycle;
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [31:0]      r_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic            w_hit;
    logic [5:0]      w_off;
    logic            w_wr;
    logic            w_wr_led;
    logic            w_wr_in_stat;
    logic            w_wr_fifo_stat;
    logic            w_push;
    logic            w_wr_cycle;
    logic            w_unused_addr_lsbs;

    assign w_hit              = (bus.io_addr[31:8] == BASE_ADDR[31:8]);
    assign w_off              = bus.io_addr[7:2];
    assign w_unused_addr_lsbs = ^bus.io_addr[1:0];
    assign w_wr               = bus.io_we & w_hit;
    assign w_wr_led           = w_wr & (w_off == c_off_led);
    assign w_wr_in_stat       = w_wr & (w_off == c_off_in_stat);
    assign w_wr_fifo_stat     = w_wr & (w_off == c_off_fifo_stat);
    assign w_push             = w_wr & (w_off == c_off_fifo_push);
    assign w_wr_cycle         = w_wr & (w_off == c_off_cycle);

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic [c_pw-1:0] w_count;
    logic [7:0]      w_count8;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_capture;

    // Extra pointer MSB makes the difference unambiguous between full and empty.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_count8  = 8'(w_count);
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == FIFO_DEPTH[c_pw-1:0]);
    assign w_pop     = ~w_empty & bus.out_ready;
    // A push into a full FIFO still fits when the head leaves the same cycle.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_capture = bus.in_valid & ~r_flag;

    assign led           = r_led;
    assign bus.in_ready  = ~r_flag;
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_empty ? 32'h0 : r_mem[r_rd_ptr[c_aw-1:0]];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_led     <= '0;
            r_flag    <= 1'b0;
            r_in_data <= '0;
            r_ovf     <= 1'b0;
            r_cycle   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            if (w_wr_led) begin
                r_led <= bus.io_dout[LED_W-1:0];
            end

            // Capture has priority; a clear only matters while flag is set,
            // and then in_ready is low so no capture can coincide.
            if (w_capture) begin
                r_flag    <= 1'b1;
                r_in_data <= bus.in_data;
            end else if (w_wr_in_stat) begin
                r_flag <= 1'b0;
            end

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end

            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_wr_fifo_stat && bus.io_dout[2]) begin
                r_ovf <= 1'b0;
            end

            if (w_wr_cycle) begin
                r_cycle <= bus.io_dout;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst && w_push_ok) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= bus.io_dout;
        end
    end

`ifdef MMIO_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_irq;
    logic       w_wr_irq_en;

    assign w_wr_irq_en = w_wr & (w_off == c_off_irq_en);
    assign irq         = r_irq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq_en <= 2'b00;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_irq_en) begin
                r_irq_en <= bus.io_dout[1:0];
            end
            r_irq <= (r_irq_en[0] & r_flag) | (r_irq_en[1] & w_empty);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux: purely combinational, so a same-cycle write is not visible
    // ------------------------------------------------------------------
    always_comb begin
        bus.io_din = 32'h0;
        if (w_hit) begin
            case (w_off)
                c_off_led:       bus.io_din = 32'(r_led);
                c_off_in_stat:   bus.io_din = {31'h0, r_flag};
                c_off_in_data:   bus.io_din = {16'h0, r_in_data};
                c_off_fifo_stat: bus.io_din = {24'h0, w_count8[3:0], 1'b0,
                                               r_ovf, w_empty, w_full};
                c_off_cycle:     bus.io_din = r_cycle;
`ifdef MMIO_IRQ_EN
                c_off_irq_en:    bus.io_din = {30'h0, r_irq_en};
`endif
                default:         bus.io_din = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_io_responder
//  Description : Self-checking bench for mmio_io_responder. Register reads
//                are compared against constants; FIFO output data is
//                compared against a scoreboard queue filled as pushes are
//                issued and drained as the consumer accepts entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_io_responder;

    localparam logic [31:0] c_led   = 32'hFFFF_FF00;
    localparam logic [31:0] c_istat = 32'hFFFF_FF04;
    localparam logic [31:0] c_idata = 32'hFFFF_FF08;
    localparam logic [31:0] c_fstat = 32'hFFFF_FF0C;
    localparam logic [31:0] c_fpush = 32'hFFFF_FF10;
    localparam logic [31:0] c_cycle = 32'hFFFF_FF14;
    localparam logic [31:0] c_irqen = 32'hFFFF_FF18;

    logic        clk;
    logic        rst;
    logic [15:0] led;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    mmio_io_responder_if bus ();

    mmio_io_responder #(
        .BASE_ADDR  (32'hFFFF_FF00),
        .FIFO_DEPTH (4),
        .LED_W      (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led)
`ifdef MMIO_IRQ_EN
        ,
        .irq (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // All driving happens 1 time unit after a posedge; tasks return there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.io_addr = a;
        bus.io_dout = d;
        bus.io_we   = 1'b1;
        tick();
        bus.io_we   = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.io_addr = a;
        #1;
        chk(tag, bus.io_din, exp);
    endtask

    task automatic fifo_push(input logic [31:0] d, input bit accept);
        if (accept) sb_q.push_back(d);
        bus_write(c_fpush, d);
    endtask

    // Consumer side: an entry seen valid with ready high leaves at the next edge.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("drain_unexpected", bus.out_data, 32'hDEAD_DEAD);
            end else begin
                chk("drain", bus.out_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        bus.io_addr = 32'h0;
        bus.io_dout = 32'h0;
        bus.io_we   = 1'b0;
        bus.in_data = 16'h0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        bus_read("rst_fstat", c_fstat, 32'h02);
        bus_read("rst_cycle", c_cycle, 32'h0);
        rst = 1'b1;

        // LED write, then read-before-write on a second store
        bus_write(c_led, 32'h0001_A5A5);
        chk("led_out", 32'(led), 32'h0000_A5A5);
        bus_read("led_rd", c_led, 32'h0000_A5A5);
        bus.io_dout = 32'h0000_00FF;
        bus.io_we   = 1'b1;
        #1;
        chk("led_rd_same_cycle", bus.io_din, 32'h0000_A5A5);
        tick();
        bus.io_we = 1'b0;
        chk("led_out2", 32'(led), 32'h0000_00FF);

        // Unmapped / miss accesses
        bus_read("unmapped_rd", 32'hFFFF_FF20, 32'h0);
        bus_read("miss_rd", 32'h1234_5600, 32'h0);
        bus_read("push_rd", c_fpush, 32'h0);
        bus_read("irqen_rd", c_irqen, 32'h0);
        bus_write(32'h1234_5600, 32'h0000_0077);
        chk("miss_wr_led", 32'(led), 32'h0000_00FF);

        // Input handshake
        bus.in_data  = 16'h1234;
        bus.in_valid = 1'b1;
        tick();
        chk("in_ready_lo", 32'(bus.in_ready), 32'h0);
        bus_read("in_stat", c_istat, 32'h1);
        bus_read("in_data", c_idata, 32'h0000_1234);
        bus.in_data = 16'h5678;
        tick();
        bus_read("in_data_hold", c_idata, 32'h0000_1234);
        bus_write(c_istat, 32'h0);
        chk("in_ready_hi", 32'(bus.in_ready), 32'h1);
        tick();
        bus_read("in_data2", c_idata, 32'h0000_5678);
        chk("in_ready_lo2", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b0;
        bus_write(c_istat, 32'h0);
        bus_read("in_stat_clr", c_istat, 32'h0);

        // Fill and overflow with consumer stalled
        fifo_push(32'd1, 1'b1);
        fifo_push(32'd2, 1'b1);
        fifo_push(32'd3, 1'b1);
        fifo_push(32'd4, 1'b1);
        bus_read("fstat_full", c_fstat, 32'h41);
        fifo_push(32'd5, 1'b0);
        bus_read("fstat_ovf", c_fstat, 32'h45);
        bus_write(c_fstat, 32'h4);
        bus_read("fstat_ovf_clr", c_fstat, 32'h41);

        // Drain: four consecutive pops
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_done_valid", 32'(bus.out_valid), 32'h0);
        chk("drain_done_data", bus.out_data, 32'h0);
        bus_read("fstat_empty", c_fstat, 32'h02);
        chk("sb_empty1", 32'(sb_q.size()), 32'h0);

        // Push into empty FIFO while consumer ready: push only
        fifo_push(32'd7, 1'b1);
        chk("empty_push_valid", 32'(bus.out_valid), 32'h1);
        tick();
        chk("empty_push_drained", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // Full push + pop in the same cycle
        fifo_push(32'd1, 1'b1);
        fifo_push(32'd2, 1'b1);
        fifo_push(32'd3, 1'b1);
        fifo_push(32'd4, 1'b1);
        bus.out_ready = 1'b1;
        fifo_push(32'd9, 1'b1);
        bus.out_ready = 1'b0;
        bus_read("fstat_pushpop", c_fstat, 32'h41);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        chk("pushpop_drained", 32'(bus.out_valid), 32'h0);
        chk("sb_empty2", 32'(sb_q.size()), 32'h0);

        // Counter load and wrap
        bus_write(c_cycle, 32'hFFFF_FFFE);
        bus_read("cycle_load", c_cycle, 32'hFFFF_FFFE);
        tick();
        bus_read("cycle_max", c_cycle, 32'hFFFF_FFFF);
        tick();
        bus_read("cycle_wrap", c_cycle, 32'h0);

`ifdef MMIO_IRQ_EN
        bus_write(c_irqen, 32'h2);
        bus_read("irqen_rd2", c_irqen, 32'h2);
        tick();
        chk("irq_empty", 32'(irq), 32'h1);
        bus_write(c_irqen, 32'h0);
        tick();
        chk("irq_off", 32'(irq), 32'h0);
`endif

        // Reset in the middle of activity
        fifo_push(32'h0000_00AA, 1'b0);
        fifo_push(32'h0000_00BB, 1'b0);
        bus.in_data  = 16'hBEEF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus_write(c_led, 32'h0000_1234);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        chk("pre_rst_ready", 32'(bus.in_ready), 32'h0);
        rst = 1'b0;
        tick();
        chk("mid_rst_led", 32'(led), 32'h0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_out_data", bus.out_data, 32'h0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
        bus_read("mid_rst_istat", c_istat, 32'h0);
        bus_read("mid_rst_idata", c_idata, 32'h0);
        bus_read("mid_rst_fstat", c_fstat, 32'h02);
        bus_read("mid_rst_cycle", c_cycle, 32'h0);
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
- Responder end of the CPU's memory-mapped IO bus (io_addr / io_dout / io_we / io_din).
- Decodes IO addresses and accepts CPU store writes.
- Returns load data combinationally on io_din.
- Bridges the bus to:
  - an LED output register,
  - a valid/ready input port (switch/button source),
  - a buffered output FIFO that drains to a display-side valid/ready consumer,
  - a free-running cycle counter.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00: IO window base. A bus access hits when io_addr[31:8] == BASE_ADDR[31:8].
- FIFO_DEPTH, 4: output FIFO entries, power of two, 2..16.
- LED_W, 16: LED register width.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- io_addr  in  32  byte address from CPU MEM stage
- io_dout  in  32  CPU store data
- io_we  in  1  CPU store strobe, one cycle per store
- io_din  out  32  read data to CPU, combinational from io_addr
- led  out  LED_W  LED register
- in_data  in  16  input port data
- in_valid  in  1  input source has data
- in_ready  out  1  responder can capture input
- out_data  out  32  FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  display consumer accepts head

Behaviour:
- Reset (rst=0 at posedge):
  - led=0, input flag=0, input data=0, overflow=0, counter=0.
  - FIFO empty: out_valid=0, out_data=0.
  - in_ready=1.
  - Reset overrides every same-cycle write, capture and pop.
- Register map (offset = io_addr[7:0]; io_addr[1:0] ignored):
  - 0x00 LED (RW): write led <= io_dout[LED_W-1:0].
  - 0x04 IN_STAT (RW): read {31'b0, flag}. Any write clears flag.
  - 0x08 IN_DATA (RO): read {16'b0, captured data}.
  - 0x0C FIFO_STAT (RW): read {24'b0, count[3:0], 1'b0, overflow, empty, full}. Write with io_dout[2]=1 clears overflow.
  - 0x10 FIFO_PUSH (WO): write pushes io_dout. Reads return 0.
  - 0x14 CYCLE (RW): read counter. Write loads io_dout; the counter then increments from the next cycle.
  - Unmapped offsets, or a miss on io_addr[31:8]: io_din=0, writes ignored.
- Writes take effect at the posedge where io_we=1 and the address hits. No wait states.
- Input handshake:
  - in_ready = ~flag.
  - Capture when in_valid & in_ready at a posedge: store data, flag <= 1.
  - A capture and a write to 0x04 in the same cycle cannot occur, because in_ready=0 whenever a clear is meaningful. If flag=0 and both happen, the capture wins and flag=1.
- Output FIFO:
  - Circular buffer, pointers of width log2(FIFO_DEPTH)+1.
  - out_data = entry at the read pointer; forced to 0 while empty.
  - Pop on out_valid & out_ready.
  - Push when not full: accepted.
  - Push when full with a pop in the same cycle: both succeed, count unchanged.
  - Push when full without a pop: data dropped, overflow <= 1 (sticky).
  - Push and pop while empty: only the push takes effect; out_valid rises next cycle.
  - Pointer wrap is silent; count = wr_ptr - rd_ptr.
- Counter: +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
- io_din is purely combinational. A read in the same cycle as a write returns the pre-write value.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and register 0x18 IRQ_EN (RW, bits[1:0]).
  - irq = (IRQ_EN[0] & flag) | (IRQ_EN[1] & empty).
  - irq is registered, so it asserts one cycle after the condition.
  - IRQ_EN resets to 0.
- Undefined: no irq port; offset 0x18 behaves as unmapped (reads 0, writes ignored).

Test Plan:
- Reset then LED write: write 0xFFFF_FF00 = 32'h0001_A5A5 -> led=16'hA5A5 next cycle; read 0xFFFF_FF00 returns 32'h0000_A5A5.
- Input handshake:
  - in_data=16'h1234 with in_valid=1 -> next cycle in_ready=0, IN_STAT reads 1, IN_DATA reads 32'h1234.
  - A second in_valid with 16'h5678 is ignored.
  - Write 0x04 -> in_ready=1, then 16'h5678 is captured.
- FIFO fill/overflow with out_ready=0:
  - Push 1,2,3,4 -> FIFO_STAT reads 32'h41.
  - Push 5 -> dropped; FIFO_STAT reads 32'h45.
  - Write 0x0C = 4 -> reads 32'h41.
- Drain order: raise out_ready -> out_data sequence 1,2,3,4 on consecutive cycles, then out_valid=0 and FIFO_STAT reads 32'h02.
- Full push+pop: FIFO full (1..4), same cycle push 9 and out_ready=1 -> count stays 4, overflow stays 0, final drain order 2,3,4,9.
- Counter and reset mid-operation:
  - Write 0x14 = 32'hFFFF_FFFE -> reads FFFF_FFFF, then 0 on the following cycles.
  - Assert rst=0 with FIFO non-empty and flag set -> next cycle all registers are 0, out_valid=0, in_ready=1.
